alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between NREQ requesters, e.g. the main execute path and a debug/address-generation port.
- Accepts R-type function codes plus operands over a valid/ready handshake and arbitrates round-robin.
- Translates each function code to the 4-bit ALU op code, drives the ALU, and routes each tagged result back to the requester that issued it.
- Sits between the control/decode logic and the ALU instance in the CPU top level.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DW, 32, operand/result width.
- LAT, 1, ALU result latency in cycles (1..4); the result for an issue in cycle t is valid in cycle t+LAT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; one-hot or zero.
- req_func  input  6*NREQ  per-requester R-type func field; requester i in bits [6i+5:6i].
- req_a  input  DW*NREQ  per-requester operand A.
- req_b  input  DW*NREQ  per-requester operand B.
- alu_issue  output  1  ALU inputs valid this cycle.
- alu_op  output  4  ALU op code.
- alu_a  output  DW  ALU operand A.
- alu_b  output  DW  ALU operand B.
- alu_result  input  DW  ALU result.
- rsp_valid  output  NREQ  one-hot response strobe.
- rsp_data  output  DW  response data.
- rsp_err  output  1  response is for an unsupported func.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: req_ready=0, alu_issue=0, alu_op=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_data=0, rsp_err=0, rr pointer=0, tag pipeline empty.
- Arbitration:
  - Combinational.
  - Grant goes to the first requester with req_valid=1, searching from the pointer upward modulo NREQ.
  - req_ready is one-hot on the granted requester; all zero if no requester is valid.
  - A transfer occurs when req_valid&req_ready. The pointer then becomes (granted+1) mod NREQ; it does not move in cycles with no transfer.
  - At most one transfer per cycle.
- Decode:
  - func 100000→1110 (ADD), 100010→0100 (SUB), 100100→0010 (AND), 100101→0011 (OR), 100110→0111 (XOR), 000000→1010 (SLL), 000010→1000 (SRL), 000011→1001 (SRA), 001000→1100 (JR).
  - Any other func is illegal.
- Issue (transfer in cycle T):
  - Legal func: alu_issue=1 in cycle T+1, with alu_op/alu_a/alu_b registered from the winner. Otherwise alu_issue=0 and alu_op/a/b hold their last values.
  - Illegal func: the requester is still granted (consumed), but no ALU issue.
- Tag pipeline:
  - Shift register of depth LAT+1.
  - Each entry holds {valid, requester index, err}.
  - One entry is pushed per transfer, whether legal or illegal.
- Response:
  - Registered; appears in cycle T+LAT+2.
  - rsp_valid has the bit of the originating requester set.
  - rsp_data = alu_result sampled in cycle T+1+LAT, or 0 if err; rsp_err=err.
  - Back-to-back transfers produce back-to-back responses in issue order; throughput is 1 per cycle.
- No response backpressure: requesters always accept rsp_valid.
- Requester holding valid:
  - req_func/a/b must be stable until the handshake.
  - A requester may drop valid before grant; the arbiter keeps no memory of it.
- Reset mid-operation: all in-flight tags are discarded immediately, no responses emerge for them, and the pointer returns to 0.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest index wins, the pointer is removed, and requester NREQ-1 may starve.
- Undefined: round-robin as above.
- Ports and latency are identical in both builds.

Decomposition:
- Package alu_arb_pkg:
  - func code constants (FUNC_ADD..FUNC_JR).
  - ALU op constants (ALUOP_ADD=4'b1110 .. ALUOP_JR=4'b1100).
  - tag struct typedef {valid, idx, err}.
  - function func_to_aluop returning {legal, op}.
- One sub-module, alu_arb_rr: a round-robin picker taking a request vector and pointer and returning a one-hot grant, compiled to fixed priority under the macro.

Test Plan:
- Single request: req0 func=100000, A=5, B=7 at T → alu_issue at T+1 with alu_op=1110; model ALU returns 12 at T+1+LAT → rsp_valid=01, rsp_data=12, rsp_err=0 at T+LAT+2.
- Contention: req0 and req1 valid continuously for 4 transfers → grants alternate 0,1,0,1; responses arrive in the same order, one per cycle.
- Illegal func: req1 func=111111 → granted, alu_issue stays 0, rsp_valid=10 with rsp_err=1 and rsp_data=0 at T+LAT+2.
- Decode sweep: all 9 legal funcs issued back-to-back on req0 → alu_op sequence 1110,0100,0010,0011,0111,1010,1000,1001,1100.
- Reset mid-flight: 2 transfers, then rst_n low for 1 cycle before their responses → no rsp_valid pulses; after release, req1-then-req0 contention grants req0 first.
- ALU_ARB_FIXED_PRIO_EN build: req0 and req1 valid for 3 cycles → req0 granted all 3 cycles, req1 never granted.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants, tag type and func decode for the ALU arbiter.
package alu_arb_pkg;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_XOR = 6'b100110;
  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;
  localparam logic [5:0] FUNC_SRA = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [3:0] ALUOP_ADD = 4'b1110;
  localparam logic [3:0] ALUOP_SUB = 4'b0100;
  localparam logic [3:0] ALUOP_AND = 4'b0010;
  localparam logic [3:0] ALUOP_OR  = 4'b0011;
  localparam logic [3:0] ALUOP_XOR = 4'b0111;
  localparam logic [3:0] ALUOP_SLL = 4'b1010;
  localparam logic [3:0] ALUOP_SRL = 4'b1000;
  localparam logic [3:0] ALUOP_SRA = 4'b1001;
  localparam logic [3:0] ALUOP_JR  = 4'b1100;

  // idx is 2 bits wide since NREQ never exceeds 4
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
    logic       err;
  } tag_t;

  // Returns {legal, op}; illegal funcs decode to all zeros.
  function automatic logic [4:0] func_to_aluop(input logic [5:0] func);
    case (func)
      FUNC_ADD: return {1'b1, ALUOP_ADD};
      FUNC_SUB: return {1'b1, ALUOP_SUB};
      FUNC_AND: return {1'b1, ALUOP_AND};
      FUNC_OR:  return {1'b1, ALUOP_OR};
      FUNC_XOR: return {1'b1, ALUOP_XOR};
      FUNC_SLL: return {1'b1, ALUOP_SLL};
      FUNC_SRL: return {1'b1, ALUOP_SRL};
      FUNC_SRA: return {1'b1, ALUOP_SRA};
      FUNC_JR:  return {1'b1, ALUOP_JR};
      default:  return 5'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Combinational one-hot picker: round-robin from ptr upward, or lowest index
// wins when ALU_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module alu_arb_rr #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++)
      if (req[i] && grant == '0) grant[i] = 1'b1;
  end
`else
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // PW+1 bits holds ptr+k without overflow, so one conditional subtract wraps it
  always_comb begin
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (req[idx] && grant == '0) grant[idx] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters; decodes func, issues, and routes tagged
// results back. ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][5:0]     req_func,
  input  logic [NREQ-1:0][DW-1:0]  req_a,
  input  logic [NREQ-1:0][DW-1:0]  req_b,
  output logic                     alu_issue,
  output logic [3:0]               alu_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  input  logic [DW-1:0]            alu_result,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic            xfer;
  logic [5:0]      win_func;
  logic [DW-1:0]   win_a, win_b;
  logic [4:0]      dec;
  tag_t [LAT:0]    tag_pipe;
  tag_t            tag_out;

  alu_arb_rr #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Grants are suppressed while reset is held so nothing is consumed then.
  assign req_ready = rst_n ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    gidx     = '0;
    win_func = '0;
    win_a    = '0;
    win_b    = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        gidx     = PW'(i);
        win_func = req_func[i];
        win_a    = req_a[i];
        win_b    = req_b[i];
      end
  end

  assign dec = func_to_aluop(win_func);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    ptr <= '0;
    else if (xfer) ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_issue <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else if (xfer && dec[4]) begin
      alu_issue <= 1'b1;
      alu_op    <= dec[3:0];
      alu_a     <= win_a;
      alu_b     <= win_b;
    end else begin
      alu_issue <= 1'b0;
    end

  // Stage k is visible LAT-k cycles before the matching ALU result; the last
  // stage lines up with alu_result.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tag_pipe <= '0;
    else begin
      tag_pipe[0] <= '{valid: xfer, idx: 2'(gidx), err: xfer & ~dec[4]};
      for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end

  assign tag_out = tag_pipe[LAT];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= tag_out.valid ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_out.idx) : '0;
      rsp_data  <= (tag_out.valid && !tag_out.err) ? alu_result : '0;
      rsp_err   <= tag_out.valid & tag_out.err;
    end

endmodule
